// File: rtl/fetch_buffer_pkg.sv
// Shared pipeline defines for the fetch buffer: NOP encoding, default depth, entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_buffer_pkg;

  localparam int          FB_DEFAULT_DEPTH = 8;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fb_entry_t;

  // Decode never takes more than two per cycle; an encoding of 3 means 2.
  function automatic logic [1:0] clamp_consume(input logic [1:0] req);
    return (req == 2'd3) ? 2'd2 : req;
  endfunction

endpackage

// File: rtl/fetch_buffer_ram.sv
// Entry storage for the fetch buffer: DEPTH x {inst, pc}, two write ports, two async read ports.
// Latency: write visible on read ports the cycle after the write edge; reads are combinational.
// Backpressure: none; the owner guarantees the two write addresses differ when both are enabled.
//
// Ports: clk; wr0_*/wr1_* (enable, address, entry); rd0_*/rd1_* (address in, entry out).
// Contents are deliberately not reset: nothing reads an entry before it has been written.
module fetch_buffer_ram
  import fetch_buffer_pkg::*;
#(
  parameter  int DEPTH = FB_DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wr0_en,
  input  logic [AW-1:0]   wr0_addr,
  input  fb_entry_t       wr0_dat,
  input  logic            wr1_en,
  input  logic [AW-1:0]   wr1_addr,
  input  fb_entry_t       wr1_dat,
  input  logic [AW-1:0]   rd0_addr,
  output fb_entry_t       rd0_dat,
  input  logic [AW-1:0]   rd1_addr,
  output fb_entry_t       rd1_dat
);

  fb_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr0_addr] <= wr0_dat;
    if (wr1_en) mem[wr1_addr] <= wr1_dat;
  end

  assign rd0_dat = mem[rd0_addr];
  assign rd1_dat = mem[rd1_addr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: circular queue of {inst, pc} between fetch and decode, two in / two out.
// Latency: an accepted fetch appears on the slot outputs one cycle later; no same-cycle bypass.
// Backpressure: stall_o asserts when fewer than two entries are free; fetches offered while stalled are dropped.
//
// Ports: clock_i, reset_i (async, active-high); fetch_valid_i/fetch_pc_i/idata_i write side;
//        flush_i discards everything; consume_i (0..2) read side; inst*/pc*/valid_o present the two
//        oldest entries; stall_o back to fetch; count_o current occupancy.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter  int DEPTH = FB_DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          fetch_valid_i,
  input  logic [31:0]   fetch_pc_i,
  input  logic [63:0]   idata_i,
  input  logic          flush_i,
  input  logic [1:0]    consume_i,
  output logic [31:0]   inst0_o,
  output logic [31:0]   inst1_o,
  output logic [31:0]   pc0_o,
  output logic [31:0]   pc1_o,
  output logic [1:0]    valid_o,
  output logic          stall_o,
  output logic [CW-1:0] count_o
);

  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic          wr_accept;
  logic          wr_aligned;
  logic [1:0]    wr_num;
  logic [1:0]    consume_req;
  logic [1:0]    rd_num;
  fb_entry_t     wr0_dat;
  fb_entry_t     wr1_dat;
  fb_entry_t     rd0_dat;
  fb_entry_t     rd1_dat;

  // Stall looks only at registered occupancy so fetch sees a clean, early signal;
  // a consume in the same cycle frees space only from the next cycle on.
  assign stall_o    = (count_q > CW'(DEPTH - 2));
  assign wr_accept  = fetch_valid_i & ~stall_o & ~flush_i;
  assign wr_aligned = ~fetch_pc_i[2];
  assign wr_num     = wr_accept ? (wr_aligned ? 2'd2 : 2'd1) : 2'd0;

  // Never pop more than is held; writes landing this cycle are not yet consumable.
  assign consume_req = clamp_consume(consume_i);
  assign rd_num      = (CW'(consume_req) > count_q) ? count_q[1:0] : consume_req;

  // A PC with bit 2 set starts mid-pair, so only the upper word is a real instruction.
  assign wr0_dat.inst = wr_aligned ? idata_i[31:0] : idata_i[63:32];
  assign wr0_dat.pc   = fetch_pc_i;
  assign wr1_dat.inst = idata_i[63:32];
  assign wr1_dat.pc   = fetch_pc_i + 32'd4;

  fetch_buffer_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk      (clock_i),
    .wr0_en   (wr_accept),
    .wr0_addr (tail_q),
    .wr0_dat  (wr0_dat),
    .wr1_en   (wr_accept & wr_aligned),
    .wr1_addr (tail_q + AW'(1)),
    .wr1_dat  (wr1_dat),
    .rd0_addr (head_q),
    .rd0_dat  (rd0_dat),
    .rd1_addr (head_q + AW'(1)),
    .rd1_dat  (rd1_dat)
  );

  // Pointers are exactly log2(DEPTH) bits wide, so natural overflow is the modulo wrap.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + AW'(rd_num);
      tail_q  <= tail_q + AW'(wr_num);
      count_q <= count_q + CW'(wr_num) - CW'(rd_num);
    end
  end

  assign valid_o[0] = (count_q != '0);
  assign valid_o[1] = (count_q >= CW'(2));
  assign count_o    = count_q;

  // Empty slots show a NOP at PC 0 so stale storage never leaks into decode.
  assign inst0_o = valid_o[0] ? rd0_dat.inst : NOP_INST;
  assign pc0_o   = valid_o[0] ? rd0_dat.pc   : 32'd0;
  assign inst1_o = valid_o[1] ? rd1_dat.inst : NOP_INST;
  assign pc1_o   = valid_o[1] ? rd1_dat.pc   : 32'd0;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed vector table, corner-case sequences,
// and randomized traffic compared against a queue-based reference model.
// Summary line reports total comparisons and failures.
module tb_fetch_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          DEP = 8;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_pc_i;
  logic [63:0] idata_i;
  logic        flush_i;
  logic [1:0]  consume_i;
  logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;
  logic [1:0]  valid_o;
  logic        stall_o;
  logic [3:0]  count_o;

  int total = 0;
  int bad   = 0;

  fetch_buffer #(.DEPTH(DEP)) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_pc_i    (fetch_pc_i),
    .idata_i       (idata_i),
    .flush_i       (flush_i),
    .consume_i     (consume_i),
    .inst0_o       (inst0_o),
    .inst1_o       (inst1_o),
    .pc0_o         (pc0_o),
    .pc1_o         (pc1_o),
    .valid_o       (valid_o),
    .stall_o       (stall_o),
    .count_o       (count_o)
  );

  always #5 clock_i = ~clock_i;

  // Reference model: an ordered list of buffered {inst, pc}.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic [63:0] idata;
    logic        fl;
    logic [1:0]  cons;
    logic [31:0] cnt;
    logic [1:0]  vld;
    logic [31:0] i0;
    logic [31:0] p0;
    logic [31:0] i1;
    logic [31:0] p1;
    logic        st;
  } vec_t;
  vec_t tbl[8];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic model_step(input logic fv, input logic [31:0] pc, input logic [63:0] idata,
                            input logic fl, input logic [1:0] cons);
    int   n;
    int   c;
    bit   full;
    ent_t e;
    n    = q.size();
    full = (DEP - n) < 2;
    if (fl) begin
      q.delete();
    end else begin
      c = (cons == 2'd3) ? 2 : int'(cons);
      if (c > n) c = n;
      repeat (c) void'(q.pop_front());
      if (fv && !full) begin
        if (!pc[2]) begin
          e.inst = idata[31:0];  e.pc = pc;          q.push_back(e);
          e.inst = idata[63:32]; e.pc = pc + 32'd4;  q.push_back(e);
        end else begin
          e.inst = idata[63:32]; e.pc = pc;          q.push_back(e);
        end
      end
    end
  endtask

  task automatic check_model(string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count_o), 32'(n));
    chk({tag, ".valid"}, 32'(valid_o), {30'd0, n >= 2, n >= 1});
    chk({tag, ".stall"}, 32'(stall_o), 32'((DEP - n) < 2));
    chk({tag, ".inst0"}, inst0_o, (n >= 1) ? q[0].inst : NOP);
    chk({tag, ".pc0"},   pc0_o,   (n >= 1) ? q[0].pc   : 32'd0);
    chk({tag, ".inst1"}, inst1_o, (n >= 2) ? q[1].inst : NOP);
    chk({tag, ".pc1"},   pc1_o,   (n >= 2) ? q[1].pc   : 32'd0);
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1ns after the edge.
  task automatic cyc(input logic fv, input logic [31:0] pc, input logic [63:0] idata,
                     input logic fl, input logic [1:0] cons);
    fetch_valid_i = fv;
    fetch_pc_i    = pc;
    idata_i       = idata;
    flush_i       = fl;
    consume_i     = cons;
    model_step(fv, pc, idata, fl, cons);
    @(posedge clock_i);
    #1;
    fetch_valid_i = 1'b0;
    flush_i       = 1'b0;
    consume_i     = 2'd0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #2;
    q.delete();
    @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still-running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i       = 1'b1;
    fetch_valid_i = 1'b0;
    fetch_pc_i    = '0;
    idata_i       = '0;
    flush_i       = 1'b0;
    consume_i     = 2'd0;

    tbl[0] = '{1'b1, 32'h00, 64'h00200093_00100093, 1'b0, 2'd0, 32'd2, 2'b11, 32'h00100093, 32'h00, 32'h00200093, 32'h04, 1'b0};
    tbl[1] = '{1'b0, 32'h00, 64'h0,                 1'b0, 2'd2, 32'd0, 2'b00, NOP,          32'h00, NOP,          32'h00, 1'b0};
    tbl[2] = '{1'b1, 32'h0C, 64'h00300113_DEADBEEF, 1'b0, 2'd0, 32'd1, 2'b01, 32'h00300113, 32'h0C, NOP,          32'h00, 1'b0};
    tbl[3] = '{1'b0, 32'h00, 64'h0,                 1'b0, 2'd3, 32'd0, 2'b00, NOP,          32'h00, NOP,          32'h00, 1'b0};
    tbl[4] = '{1'b1, 32'h10, 64'hAAAA0002_AAAA0001, 1'b0, 2'd0, 32'd2, 2'b11, 32'hAAAA0001, 32'h10, 32'hAAAA0002, 32'h14, 1'b0};
    tbl[5] = '{1'b1, 32'h18, 64'hBBBB0002_BBBB0001, 1'b0, 2'd1, 32'd3, 2'b11, 32'hAAAA0002, 32'h14, 32'hBBBB0001, 32'h18, 1'b0};
    tbl[6] = '{1'b1, 32'h20, 64'hDDDD0002_DDDD0001, 1'b1, 2'd2, 32'd0, 2'b00, NOP,          32'h00, NOP,          32'h00, 1'b0};
    tbl[7] = '{1'b1, 32'h24, 64'hCCCC0001_EEEE0000, 1'b0, 2'd2, 32'd1, 2'b01, 32'hCCCC0001, 32'h24, NOP,          32'h00, 1'b0};

    // Reset state while reset is held.
    #12;
    chk("rst.count", 32'(count_o), 32'd0);
    chk("rst.valid", 32'(valid_o), 32'd0);
    chk("rst.stall", 32'(stall_o), 32'd0);
    chk("rst.inst0", inst0_o, NOP);
    chk("rst.inst1", inst1_o, NOP);
    chk("rst.pc0",   pc0_o,   32'd0);
    chk("rst.pc1",   pc1_o,   32'd0);
    @(negedge clock_i);
    reset_i = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].fv, tbl[i].pc, tbl[i].idata, tbl[i].fl, tbl[i].cons);
      chk($sformatf("vec%0d.count", i), 32'(count_o), tbl[i].cnt);
      chk($sformatf("vec%0d.valid", i), 32'(valid_o), 32'(tbl[i].vld));
      chk($sformatf("vec%0d.stall", i), 32'(stall_o), 32'(tbl[i].st));
      chk($sformatf("vec%0d.inst0", i), inst0_o, tbl[i].i0);
      chk($sformatf("vec%0d.pc0",   i), pc0_o,   tbl[i].p0);
      chk($sformatf("vec%0d.inst1", i), inst1_o, tbl[i].i1);
      chk($sformatf("vec%0d.pc1",   i), pc1_o,   tbl[i].p1);
    end

    // Full buffer: 4 aligned fetches fill it, a 5th is dropped, a consume frees it.
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h40 + 32'(8 * i), {32'h1000_0000 + 32'(2 * i + 1), 32'h1000_0000 + 32'(2 * i)}, 1'b0, 2'd0);
    chk("full.count", 32'(count_o), 32'd8);
    chk("full.stall", 32'(stall_o), 32'd1);
    cyc(1'b1, 32'h80, 64'h2222_2222_1111_1111, 1'b0, 2'd0);
    chk("drop.count", 32'(count_o), 32'd8);
    chk("drop.pc0",   pc0_o,        32'h40);
    cyc(1'b0, 32'h0, 64'h0, 1'b0, 2'd2);
    chk("drain.count", 32'(count_o), 32'd6);
    chk("drain.stall", 32'(stall_o), 32'd0);
    chk("drain.pc0",   pc0_o,        32'h48);
    chk("drain.inst0", inst0_o,      32'h1000_0002);

    // Flush beats a simultaneous write and consume.
    cyc(1'b0, 32'h0, 64'h0, 1'b0, 2'd2);
    chk("preflush.count", 32'(count_o), 32'd4);
    cyc(1'b1, 32'h90, 64'h3333_3333_4444_4444, 1'b1, 2'd2);
    chk("flush.count", 32'(count_o), 32'd0);
    chk("flush.valid", 32'(valid_o), 32'd0);
    chk("flush.inst0", inst0_o,      NOP);
    cyc(1'b1, 32'h9C, 64'h0055_0013_0000_0000, 1'b0, 2'd0);
    chk("one.count", 32'(count_o), 32'd1);
    cyc(1'b0, 32'h0, 64'h0, 1'b0, 2'd2);
    chk("over.count", 32'(count_o), 32'd0);

    // Wrap: steady stream of pairs consumed two per cycle keeps order across the wrap.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 32'(8 * i), {32'h5000_0000 + 32'(2 * i + 1), 32'h5000_0000 + 32'(2 * i)}, 1'b0, 2'd2);
      chk($sformatf("wrap%0d.pc0", i),   pc0_o,        32'(8 * i));
      chk($sformatf("wrap%0d.inst0", i), inst0_o,      32'h5000_0000 + 32'(2 * i));
      chk($sformatf("wrap%0d.count", i), 32'(count_o), 32'd2);
    end
    cyc(1'b0, 32'h0, 64'h0, 1'b0, 2'd2);
    chk("wrap.end.count", 32'(count_o), 32'd0);

    // Asynchronous reset between edges at count 5.
    cyc(1'b1, 32'h100, 64'h6000_0001_6000_0000, 1'b0, 2'd0);
    cyc(1'b1, 32'h108, 64'h6000_0003_6000_0002, 1'b0, 2'd0);
    cyc(1'b1, 32'h114, 64'h6000_0004_0000_0000, 1'b0, 2'd0);
    chk("pre_arst.count", 32'(count_o), 32'd5);
    @(negedge clock_i);
    #1 reset_i = 1'b1;
    #1;
    chk("arst.count", 32'(count_o), 32'd0);
    chk("arst.valid", 32'(valid_o), 32'd0);
    #1 reset_i = 1'b0;
    q.delete();
    cyc(1'b1, 32'h200, 64'h7000_0001_7000_0000, 1'b0, 2'd0);
    check_model("post_arst");

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        fv;
      logic [31:0] pc;
      logic [63:0] idata;
      logic        fl;
      logic [1:0]  cons;
      fv    = ($urandom % 4) != 0;
      pc    = {$urandom} & 32'hFFFF_FFFC;
      idata = {$urandom, $urandom};
      fl    = ($urandom % 40) == 0;
      cons  = ((i % 400) < 200) ? 2'($urandom % 2) : 2'($urandom % 4);
      cyc(fv, pc, idata, fl, cons);
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 DEPTH, 8, instruction entries held; power of two, >= 4.
REQ-002 clock_i  in  1  single clock, rising edge.
REQ-003 reset_i  in  1  asynchronous, active-high reset.
REQ-004 fetch_valid_i  in  1  idata_i/fetch_pc_i carry a fetched pair this cycle.
REQ-005 fetch_pc_i  in  32  fetch PC; bit 2 selects the starting word.
REQ-006 idata_i  in  64  imem pair; [31:0] at PC&~7, [63:32] at (PC&~7)+4.
REQ-007 flush_i  in  1  redirect; discard all buffered instructions.
REQ-008 consume_i  in  2  instructions taken by decode this cycle (0, 1, 2).
REQ-009 inst0_o  out  32  oldest buffered instruction.
REQ-010 inst1_o  out  32  second-oldest buffered instruction.
REQ-011 pc0_o  out  32  PC of inst0_o.
REQ-012 pc1_o  out  32  PC of inst1_o.
REQ-013 valid_o  out  2  bit0 qualifies slot 0, bit1 qualifies slot 1.
REQ-014 stall_o  out  1  to fetch1: fewer than 2 free entries; fetch1 holds PC.
REQ-015 count_o  out  log2(DEPTH)+1  current occupancy.

Function
REQ-016 Circular buffer of {inst[31:0], pc[31:0]}; head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; occupancy in registered count.
REQ-017 Write accepted when fetch_valid_i=1, stall_o=0, flush_i=0.
REQ-018 Accepted write, fetch_pc_i[2]=0: two entries at tail, tail+1 = {idata_i[31:0], fetch_pc_i}, {idata_i[63:32], fetch_pc_i+4}; tail += 2.
REQ-019 Accepted write, fetch_pc_i[2]=1: one entry {idata_i[63:32], fetch_pc_i}; tail += 1.
REQ-020 fetch_valid_i while stall_o=1: data dropped, no state change.
REQ-021 Read: effective consume = min(consume_i, count); consume_i=3 treated as 2; head += effective consume.
REQ-022 Outputs combinational from registered state: slot0 = entry[head], slot1 = entry[head+1]; valid_o[0] = count>=1, valid_o[1] = count>=2.
REQ-023 Invalid slot drives inst = NOP (0x00000013), pc = 0.
REQ-024 Write-to-output latency: one cycle; no same-cycle bypass.
REQ-025 Same-cycle read and write: count_next = count + written - consumed; both must apply.
REQ-026 stall_o = (DEPTH - count) < 2, from registered count only; same-cycle consume does not clear stall.
REQ-027 flush_i priority over write and consume: next cycle head = tail = count = 0.
REQ-028 Order preserved across pointer wrap; no entry lost or duplicated.

Reset
REQ-029 reset_i=1 forces head=0, tail=0, count=0 immediately, no clock edge needed.
REQ-030 Reset outputs: valid_o=2'b00, stall_o=0, count_o=0, inst0_o/inst1_o=0x00000013, pc0_o/pc1_o=0.
REQ-031 Storage array not reset; contents unobservable until written.
REQ-032 Reset mid-operation discards all entries; first write after release lands at entry 0.

Structure
REQ-033 NOP encoding (0x00000013) and default DEPTH live in the shared pipeline defines header.
REQ-034 One sub-module natural: fetch_buffer_ram (DEPTH x 64, two write ports, two read ports); pointer/count logic stays in fetch_buffer.

Verification
REQ-035 Aligned fetch: pc=0x0, idata=0x00200093_00100093 -> next cycle valid_o=11, inst0=0x00100093/pc0=0x0, inst1=0x00200093/pc1=0x4, count=2.
REQ-036 Misaligned fetch: pc=0xC, idata[63:32]=0x00300113 -> valid_o=01, inst0=0x00300113, pc0=0xC, inst1=0x00000013, count=1.
REQ-037 Full: 4 aligned fetches, consume 0 -> count=8, stall_o=1; 5th fetch dropped, count=8; consume=2 -> count=6, stall_o=0.
REQ-038 Wrap: 7 aligned fetches (PCs 0x0-0x34), consume=2 every cycle -> pc0_o sequence 0x0, 0x8, ... 0x30 in order, count ends 0.
REQ-039 Flush: count=4, flush_i=1 with fetch_valid_i=1, consume_i=2 -> next cycle count=0, valid_o=00, inst0=0x00000013; consume_i=2 at count=1 -> count=0.
REQ-040 Async reset at count=5 between clock edges -> count_o=0, valid_o=00 before next edge.
